speech_cmd_decider: RTL and testbench

//  Producer side of the 2-bit speech_rec command code: 00 none, 01 "on", 10 "off".

---
 rtl/speech_cmd_decider_if.sv | 23 ++
 rtl/speech_cmd_decider.sv | 148 ++++++++++++++
 tb/tb_speech_cmd_decider.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/speech_cmd_decider_if.sv
// Frame-score input and command-code output bundle between template matcher, decider and LED control.
// Master drives frames (matcher side); slave is the decider.
interface speech_cmd_decider_if #(
  parameter int SCORE_W = 8
);
  logic               vad;
  logic               frame_valid;
  logic [SCORE_W-1:0] score_on;
  logic [SCORE_W-1:0] score_off;
  logic [1:0]         speech_rec;
  logic               rec_valid;
  logic               busy;

  modport master (
    output vad, frame_valid, score_on, score_off,
    input  speech_rec, rec_valid, busy
  );

  modport slave (
    input  vad, frame_valid, score_on, score_off,
    output speech_rec, rec_valid, busy
  );
endinterface

// File: rtl/speech_cmd_decider.sv
// Sums on/off frame scores over a voiced window and emits a 1-cycle command code (00/01/10).
// Latency: last frame at T -> rec_valid at T+2; no backpressure, frames are accepted or dropped.
module speech_cmd_decider #(
  parameter int SCORE_W         = 8,
  parameter int WIN_FRAMES      = 4,
  parameter int THRESH          = 400,
  parameter int MARGIN          = 50,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic          clk,
  input  logic          rst,
  speech_cmd_decider_if.slave bus
);

  localparam int SW = SCORE_W + $clog2(WIN_FRAMES) + 1;
  localparam int CW = $clog2(WIN_FRAMES + 1);
  localparam int KW = $clog2(COOLDOWN_FRAMES + 1);

  localparam logic [CW-1:0] WIN_LAST  = CW'(WIN_FRAMES - 1);
  localparam logic [KW-1:0] COOL_LAST = KW'(COOLDOWN_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DECIDE,
    COOLDOWN
  } state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] sum_on, sum_on_nxt;
  logic [SW-1:0] sum_off, sum_off_nxt;
  logic [CW-1:0] frame_cnt, frame_cnt_nxt;
  logic [KW-1:0] cool_cnt, cool_cnt_nxt;
  logic [1:0]    rec, rec_nxt;
  logic          rv, rv_nxt;

  logic [SW-1:0] ext_on;
  logic [SW-1:0] ext_off;
  int            diff_on;
  int            diff_off;
  logic          win_on;
  logic          win_off;
  logic [1:0]    code;

  assign ext_on  = SW'(bus.score_on);
  assign ext_off = SW'(bus.score_off);

  // Differences are taken in 32-bit signed space so a losing sum never wraps into a pass.
  always_comb begin
    diff_on  = int'(sum_on) - int'(sum_off);
    diff_off = int'(sum_off) - int'(sum_on);
    win_on   = (int'(sum_on) >= THRESH) && (diff_on >= MARGIN);
    win_off  = (int'(sum_off) >= THRESH) && (diff_off >= MARGIN);
    code     = 2'b00;
    if (win_on) begin
      code = 2'b01;
    end else if (win_off) begin
      code = 2'b10;
    end
  end

  always_comb begin
    state_nxt     = state;
    sum_on_nxt    = sum_on;
    sum_off_nxt   = sum_off;
    frame_cnt_nxt = frame_cnt;
    cool_cnt_nxt  = cool_cnt;
    rec_nxt       = 2'b00;
    rv_nxt        = 1'b0;

    case (state)
      IDLE: begin
        if (bus.frame_valid && bus.vad) begin
          sum_on_nxt    = ext_on;
          sum_off_nxt   = ext_off;
          frame_cnt_nxt = CW'(1);
          state_nxt     = ACCUM;
        end
      end

      ACCUM: begin
        if (!bus.vad) begin
          sum_on_nxt    = '0;
          sum_off_nxt   = '0;
          frame_cnt_nxt = '0;
          state_nxt     = IDLE;
        end else if (bus.frame_valid) begin
          sum_on_nxt    = sum_on + ext_on;
          sum_off_nxt   = sum_off + ext_off;
          frame_cnt_nxt = frame_cnt + CW'(1);
          if (frame_cnt == WIN_LAST) begin
            state_nxt = DECIDE;
          end
        end
      end

      DECIDE: begin
        rv_nxt       = 1'b1;
        rec_nxt      = code;
        cool_cnt_nxt = '0;
        state_nxt    = COOLDOWN;
      end

      COOLDOWN: begin
        if (bus.frame_valid) begin
          if (cool_cnt == COOL_LAST) begin
            sum_on_nxt    = '0;
            sum_off_nxt   = '0;
            frame_cnt_nxt = '0;
            cool_cnt_nxt  = '0;
            state_nxt     = IDLE;
          end else begin
            cool_cnt_nxt = cool_cnt + KW'(1);
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sum_on    <= '0;
      sum_off   <= '0;
      frame_cnt <= '0;
      cool_cnt  <= '0;
      rec       <= 2'b00;
      rv        <= 1'b0;
    end else begin
      state     <= state_nxt;
      sum_on    <= sum_on_nxt;
      sum_off   <= sum_off_nxt;
      frame_cnt <= frame_cnt_nxt;
      cool_cnt  <= cool_cnt_nxt;
      rec       <= rec_nxt;
      rv        <= rv_nxt;
    end
  end

  assign bus.speech_rec = rec;
  assign bus.rec_valid  = rv;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_speech_cmd_decider.sv
// Directed bench for speech_cmd_decider: table of 4-frame windows plus hand-written abort/cooldown/reset sequences.
module tb_speech_cmd_decider;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  speech_cmd_decider_if #(.SCORE_W(8)) bus ();

  speech_cmd_decider dut (
    .clk(clk),
    .rst(rst_n),
    .bus(bus)
  );

  typedef struct {
    string            name;
    logic [3:0][7:0]  on;
    logic [3:0][7:0]  off;
    logic [1:0]       code;
  } vec_t;

  vec_t vecs[11];
  int   errors = 0;
  int   checks = 0;
  int   pulses = 0;
  int   exp_pulses = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Code must be zero outside the strobe, never 11; every strobe is tallied.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      chk("stray_code",
          32'(((bus.speech_rec != 2'b00) && !bus.rec_valid) || (bus.speech_rec == 2'b11)), 0);
      if (bus.rec_valid) pulses++;
    end
  end

  task automatic send_frame(input logic v, input logic [7:0] son, input logic [7:0] soff);
    @(negedge clk);
    bus.vad         = v;
    bus.frame_valid = 1'b1;
    bus.score_on    = son;
    bus.score_off   = soff;
    @(negedge clk);
    bus.frame_valid = 1'b0;
  endtask

  task automatic send_window(input logic [3:0][7:0] on, input logic [3:0][7:0] off);
    for (int i = 0; i < 4; i++) send_frame(1'b1, on[i], off[i]);
  endtask

  // Entered at the negedge of the DECIDE cycle (T+1).
  task automatic expect_decision(input string nm, input logic [1:0] code);
    chk({nm, "_rv_T1"}, 32'(bus.rec_valid), 0);
    chk({nm, "_busy_T1"}, 32'(bus.busy), 1);
    @(negedge clk);
    chk({nm, "_rv_T2"}, 32'(bus.rec_valid), 1);
    chk({nm, "_code_T2"}, 32'(bus.speech_rec), 32'(code));
    exp_pulses++;
    @(negedge clk);
    chk({nm, "_rv_T3"}, 32'(bus.rec_valid), 0);
    chk({nm, "_code_T3"}, 32'(bus.speech_rec), 0);
  endtask

  task automatic cooldown(input int n);
    for (int i = 0; i < n; i++) send_frame(i[0], 8'd255, 8'd0);
  endtask

  initial begin
    vecs[0]  = '{"on_800_200",   {4{8'd200}}, {4{8'd50}},  2'b01};
    vecs[1]  = '{"off_400_600",  {4{8'd100}}, {4{8'd150}}, 2'b10};
    vecs[2]  = '{"margin_40",    {4{8'd120}}, {4{8'd110}}, 2'b00};
    vecs[3]  = '{"below_thresh", {4{8'd90}},  {4{8'd0}},   2'b00};
    vecs[4]  = '{"thresh_exact", {4{8'd100}}, {4{8'd87}},  2'b01};
    vecs[5]  = '{"thresh_399",   {8'd99, 8'd100, 8'd100, 8'd100}, {4{8'd0}}, 2'b00};
    vecs[6]  = '{"margin_50_on", {4{8'd120}}, {8'd108, 8'd108, 8'd108, 8'd106}, 2'b01};
    vecs[7]  = '{"margin_50_off", {8'd108, 8'd108, 8'd108, 8'd106}, {4{8'd120}}, 2'b10};
    vecs[8]  = '{"margin_49",    {4{8'd120}}, {8'd108, 8'd108, 8'd108, 8'd107}, 2'b00};
    vecs[9]  = '{"tie_max",      {4{8'd255}}, {4{8'd255}}, 2'b00};
    vecs[10] = '{"all_zero",     {4{8'd0}},   {4{8'd0}},   2'b00};

    bus.vad = 1'b0;
    bus.frame_valid = 1'b0;
    bus.score_on = '0;
    bus.score_off = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_rv", 32'(bus.rec_valid), 0);
    chk("reset_code", 32'(bus.speech_rec), 0);
    chk("reset_busy", 32'(bus.busy), 0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Frame without voice is ignored in IDLE.
    send_frame(1'b0, 8'd200, 8'd0);
    chk("novad_idle_busy", 32'(bus.busy), 0);

    foreach (vecs[k]) begin
      send_window(vecs[k].on, vecs[k].off);
      expect_decision(vecs[k].name, vecs[k].code);
      cooldown(8);
      chk({vecs[k].name, "_busy_after_cd"}, 32'(bus.busy), 0);
    end

    // Voice drops mid-window: abort, then a fresh window must not see stale sums.
    send_frame(1'b1, 8'd255, 8'd0);
    send_frame(1'b1, 8'd255, 8'd0);
    chk("abort_busy_accum", 32'(bus.busy), 1);
    bus.vad = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_rv", 32'(bus.rec_valid), 0);
    send_window({4{8'd100}}, {4{8'd150}});
    expect_decision("after_abort", 2'b10);
    cooldown(8);

    // Frame during DECIDE is not a cooldown frame; 9th strobe onward opens a new window.
    send_window({4{8'd200}}, {4{8'd50}});
    bus.frame_valid = 1'b1;
    bus.score_on = 8'd255;
    @(negedge clk);
    bus.frame_valid = 1'b0;
    chk("cd_decide_rv", 32'(bus.rec_valid), 1);
    chk("cd_decide_code", 32'(bus.speech_rec), 1);
    exp_pulses++;
    cooldown(7);
    chk("cd_7_busy", 32'(bus.busy), 1);
    cooldown(1);
    chk("cd_8_busy", 32'(bus.busy), 0);
    send_window({4{8'd100}}, {4{8'd150}});
    expect_decision("post_cd", 2'b10);
    cooldown(8);

    // Async reset mid-ACCUM.
    send_frame(1'b1, 8'd255, 8'd0);
    send_frame(1'b1, 8'd255, 8'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_accum_busy", 32'(bus.busy), 0);
    chk("rst_accum_rv", 32'(bus.rec_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) send_frame(1'b1, 8'd100, 8'd150);
    repeat (3) @(negedge clk);
    chk("rst_partial_busy", 32'(bus.busy), 1);
    chk("rst_partial_rv", 32'(bus.rec_valid), 0);
    send_frame(1'b1, 8'd100, 8'd150);
    expect_decision("rst_full_win", 2'b10);
    cooldown(8);

    // Async reset inside the strobe cycle.
    send_window({4{8'd200}}, {4{8'd50}});
    @(negedge clk);
    chk("rst_rv_pre", 32'(bus.rec_valid), 1);
    exp_pulses++;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rv_rv", 32'(bus.rec_valid), 0);
    chk("rst_rv_code", 32'(bus.speech_rec), 0);
    chk("rst_rv_busy", 32'(bus.busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    send_window({4{8'd200}}, {4{8'd50}});
    expect_decision("rst_recover", 2'b01);
    cooldown(8);

    repeat (2) @(negedge clk);
    chk("pulse_count", 32'(pulses), 32'(exp_pulses));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
